sync_req_arbiter: RTL and testbench

SYNC_REQ_ARBITER -- requirements
Module: sync_req_arbiter

---
 rtl/sync_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_sync_req_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter that funnels N_REQ event requesters through one
// 4-phase crossing channel. Define SYNC_ARB_TIMEOUT_EN to add an ack-wait timeout.
`timescale 1ns/1ps
module sync_req_arbiter #(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_i,
   input  logic                     sync_ack_i,
   output logic                     sync_pulse_o,
   output logic [N_REQ-1:0]         grant_o,
   output logic [$clog2(N_REQ)-1:0] grant_id_o,
   output logic                     busy_o,
   output logic [N_REQ-1:0]         pending_o,
   output logic                     timeout_o
);
   localparam int IDW = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
      $error("sync_req_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   gid_q, gid_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             pulse_q, pulse_d;
   logic             win_vld;
   logic [IDW-1:0]   win_idx;
   logic             fire;

`ifdef SYNC_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        to_q, to_d;
`endif

   // Round-robin search from ptr upward with wrap; the lowest offset wins.
   always_comb begin
      logic [IDW-1:0] idx;
      win_vld = 1'b0;
      win_idx = '0;
      idx     = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = IDW'((int'(ptr_q) + k) % N_REQ);
         if (pending_q[idx]) begin
            win_vld = 1'b1;
            win_idx = idx;
         end
      end
   end

   assign fire = (state_q == IDLE) && win_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gid_q     <= '0;
         pending_q <= '0;
         grant_q   <= '0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gid_q     <= gid_d;
         pending_q <= pending_d;
         grant_q   <= grant_d;
         pulse_q   <= pulse_d;
      end
   end

`ifdef SYNC_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
`ifdef SYNC_ARB_TIMEOUT_EN
      to_d    = 1'b0;
`endif
      case (state_q)
         IDLE:    if (win_vld)     state_d = WAIT_HI;
         WAIT_HI: if (sync_ack_i)  state_d = WAIT_LO;
         WAIT_LO: if (!sync_ack_i) state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
`ifdef SYNC_ARB_TIMEOUT_EN
      // A normal return to IDLE on the same edge takes precedence over timeout.
      if (state_q != IDLE && state_d != IDLE && cnt_q == TO_LAST) begin
         state_d = IDLE;
         to_d    = 1'b1;
      end
`endif
   end

   always_comb begin
      pulse_d = fire;
      grant_d = '0;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      if (fire) begin
         grant_d[win_idx] = 1'b1;
         gid_d            = win_idx;
         ptr_d            = IDW'((int'(win_idx) + 1) % N_REQ);
      end
      // New request beats the grant's clear on the same bit.
      pending_d = (pending_q & ~grant_d) | req_i;
`ifdef SYNC_ARB_TIMEOUT_EN
      if (fire)                  cnt_d = '0;
      else if (state_q != IDLE)  cnt_d = cnt_q + 16'd1;
      else                       cnt_d = cnt_q;
`endif
      busy_o = (state_q != IDLE);
   end

   assign sync_pulse_o = pulse_q;
   assign grant_o      = grant_q;
   assign grant_id_o   = gid_q;
   assign pending_o    = pending_q;
`ifdef SYNC_ARB_TIMEOUT_EN
   assign timeout_o    = to_q;
`else
   assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Bench for sync_req_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the arbitration rules.
`timescale 1ns/1ps
module tb_sync_req_arbiter;
  localparam int N  = 4;
  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_i = '0;
  logic         sync_ack_i = 1'b0;
  logic         sync_pulse_o, busy_o, timeout_o;
  logic [N-1:0] grant_o, pending_o;
  logic [1:0]   grant_id_o;

  always #5 clk = ~clk;

  sync_req_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .sync_ack_i(sync_ack_i),
    .sync_pulse_o(sync_pulse_o), .grant_o(grant_o), .grant_id_o(grant_id_o),
    .busy_o(busy_o), .pending_o(pending_o), .timeout_o(timeout_o));

  int n_chk = 0, n_pass = 0;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_pend, m_gnt;
  int           m_ptr, m_gid, m_cnt;
  bit           m_busy, m_hi, m_pulse, m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= '0; m_gnt <= '0; m_ptr <= 0; m_gid <= 0; m_cnt <= 0;
      m_busy <= 0; m_hi <= 0; m_pulse <= 0; m_to <= 0;
    end else begin : mdl
      int w, nptr, ngid, ncnt, idx;
      logic [N-1:0] np, ng;
      bit nbusy, nhi, npulse, nto;
      w = -1; np = m_pend; ng = '0; nptr = m_ptr; ngid = m_gid; ncnt = m_cnt;
      nbusy = m_busy; nhi = m_hi; npulse = 0; nto = 0;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (w < 0 && m_pend[idx]) w = idx;
        end
        if (w >= 0) begin
          npulse = 1; ng[w] = 1'b1; ngid = w; nptr = (w + 1) % N;
          nbusy = 1; nhi = 0; ncnt = 0; np[w] = 1'b0;
        end
      end else begin
        ncnt = m_cnt + 1;
        if (m_hi && !sync_ack_i) nbusy = 0;
        else if (!m_hi && sync_ack_i) nhi = 1;
`ifdef SYNC_ARB_TIMEOUT_EN
        if (nbusy && ncnt == TO) begin nbusy = 0; nto = 1; end
`endif
      end
      np = np | req_i;
      m_pend <= np; m_gnt <= ng; m_ptr <= nptr; m_gid <= ngid; m_cnt <= ncnt;
      m_busy <= nbusy; m_hi <= nhi; m_pulse <= npulse; m_to <= nto;
    end
  end

  always @(negedge clk) begin
    chk("pulse",   sync_pulse_o, m_pulse);
    chk("grant",   grant_o,      m_gnt);
    chk("grantid", grant_id_o,   m_gid);
    chk("busy",    busy_o,       m_busy);
    chk("pending", pending_o,    m_pend);
    chk("timeout", timeout_o,    m_to);
  end

  int gq[$];
  always @(negedge clk) if (sync_pulse_o) gq.push_back(int'(grant_id_o));

  // ---------------- stimulus ----------------
  bit auto_ack = 0, noise = 0;
  int dly = -1, hold = 0;

  task automatic cycle(input logic [N-1:0] r);
    req_i = r;
    @(posedge clk); #2;
    req_i = '0;
    if (auto_ack) begin
      if (sync_pulse_o) dly = $urandom_range(0, 3);
      if (dly == 0) begin sync_ack_i = 1'b1; hold = $urandom_range(1, 4); dly = -1; end
      else if (dly > 0) dly--;
      else if (sync_ack_i) begin
        if (hold > 0) hold--;
        if (hold == 0) sync_ack_i = 1'b0;
      end
      if (noise && $urandom_range(0, 49) == 0) sync_ack_i = ~sync_ack_i;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_i = '0; sync_ack_i = 1'b0; dly = -1; hold = 0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    gq.delete();
  endtask

  task automatic wait_idle(input int maxc, input int ngr, input string nm);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      cycle('0);
      ok = !busy_o && pending_o == '0 && gq.size() >= ngr;
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    bit stall_ok;
    int n1;

    // reset state and single request
    do_reset();
    chk("rst_pulse", sync_pulse_o, 0); chk("rst_grant", grant_o, 0);
    chk("rst_gid", grant_id_o, 0);     chk("rst_busy", busy_o, 0);
    chk("rst_pend", pending_o, 0);     chk("rst_to", timeout_o, 0);
    cycle(4'b0001);
    chk("t1_pend", pending_o, 4'b0001); chk("t1_early", sync_pulse_o, 0);
    cycle('0);
    chk("t1_pulse", sync_pulse_o, 1); chk("t1_grant", grant_o, 4'b0001);
    chk("t1_gid", grant_id_o, 0);     chk("t1_busy", busy_o, 1);
    chk("t1_model_pulse", m_pulse, 1);
    cycle('0);
    chk("t1_pulse_once", sync_pulse_o, 0);
    cycle('0); sync_ack_i = 1'b1;
    repeat (4) cycle('0);
    chk("t1_busy_lo", busy_o, 1);
    sync_ack_i = 1'b0; cycle('0);
    chk("t1_idle", busy_o, 0);

    // all four at once, ack looped back
    do_reset(); auto_ack = 1;
    cycle(4'b1111);
    wait_idle(200, 4, "t2_done");
    chk("t2_count", gq.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_order", (i < gq.size()) ? gq[i] : -1, i);
    chk("t2_pend", pending_o, 0);

    // wrap-around from ptr=3
    do_reset();
    cycle(4'b0100);
    wait_idle(50, 1, "t3_first");
    chk("t3_g2", gq.size() > 0 ? gq[0] : -1, 2);
    gq.delete();
    cycle(4'b1001);
    wait_idle(100, 2, "t3_done");
    chk("t3_g3", gq.size() > 0 ? gq[0] : -1, 3);
    chk("t3_g0", gq.size() > 1 ? gq[1] : -1, 0);

    // set beats clear on the grant cycle
    do_reset(); auto_ack = 0;
    cycle(4'b0001); cycle('0);
    cycle(4'b0010);
    chk("t4_pend_wait", pending_o, 4'b0010); chk("t4_busy", busy_o, 1);
    sync_ack_i = 1'b1; cycle('0); cycle('0);
    sync_ack_i = 1'b0; cycle('0);
    chk("t4_idle", busy_o, 0);
    cycle(4'b0010);
    chk("t4_gid", grant_id_o, 1); chk("t4_pulse", sync_pulse_o, 1);
    chk("t4_setwins", pending_o, 4'b0010);
    sync_ack_i = 1'b1; cycle('0); sync_ack_i = 1'b0; cycle('0);
    cycle('0);
    chk("t4_pulse2", sync_pulse_o, 1); chk("t4_pend0", pending_o, 0);
    sync_ack_i = 1'b1; cycle('0); sync_ack_i = 1'b0; cycle('0);
    n1 = 0;
    foreach (gq[i]) if (gq[i] == 1) n1++;
    chk("t4_n1", n1, 2);

    // reset mid-handshake
    do_reset();
    cycle(4'b0001); cycle('0); cycle(4'b0110);
    sync_ack_i = 1'b1; cycle('0);
    chk("t5_pend", pending_o, 4'b0110); chk("t5_busy", busy_o, 1);
    rst_n = 1'b0; #1;
    chk("t5_pulse", sync_pulse_o, 0); chk("t5_grant", grant_o, 0);
    chk("t5_gid", grant_id_o, 0);     chk("t5_busy0", busy_o, 0);
    chk("t5_pend0", pending_o, 0);    chk("t5_to", timeout_o, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle('0);
      chk("t5_nopulse", sync_pulse_o, 0); chk("t5_idle", busy_o, 0);
    end
    sync_ack_i = 1'b0;

    // ack never returns
    do_reset();
    cycle(4'b0011); cycle('0);
`ifdef SYNC_ARB_TIMEOUT_EN
    repeat (9) cycle('0);
    chk("t6_to_early", timeout_o, 0); chk("t6_busy", busy_o, 1);
    cycle('0);
    chk("t6_to", timeout_o, 1); chk("t6_idle", busy_o, 0);
    cycle('0);
    chk("t6_to_once", timeout_o, 0); chk("t6_next", sync_pulse_o, 1);
    chk("t6_gid", grant_id_o, 1);
`else
    stall_ok = 1;
    repeat (1000) begin
      cycle('0);
      if (!busy_o || timeout_o) stall_ok = 0;
    end
    chk("t6_stall", stall_ok, 1);
`endif

    // randomized traffic, one reset in the middle
    do_reset(); auto_ack = 1; noise = 1;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      if (c == 1500) begin
        rst_n = 1'b0; sync_ack_i = 1'b0; dly = -1; hold = 0;
        cycle('0);
        rst_n = 1'b1;
      end
      cycle(r);
    end
    auto_ack = 0; noise = 0; sync_ack_i = 1'b0;
    repeat (2) cycle('0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
